// File: rtl/bram_arb_pkg.sv
// Shared defaults and helpers for the BRAM round-robin arbiter and its sub-blocks.
package bram_arb_pkg;

    localparam int DEF_NREQ       = 2;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_SIZE       = 16;
    localparam int DEF_BIT_WIDTH  = 32;
    localparam int MAX_REQ        = 8;

    // OR-accumulate so a one-hot input maps to its bit position without a priority chain.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves to the winner on each grant edge.
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr_reg;
    logic          found;
    int            pos;

    // Search begins just after the last winner so every requester gets a turn.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 1; k <= N; k++) begin
            pos = (int'(ptr_reg) + k) % N;
            if (!found && req[pos]) begin
                gnt[pos] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign gnt_idx = IW'(onehot_to_idx(MAX_REQ'(gnt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= IW'(N - 1);
        end else if (|req) begin
            ptr_reg <= gnt_idx;
        end
    end

endmodule

// File: rtl/bram16_rr_arbiter.sv
// Shares one simple-dual-port BRAM between NREQ requesters with independent round-robin
// read/write arbitration, out-of-range guarding and optional same-cycle write->read forwarding.
module bram16_rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NREQ       = DEF_NREQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SIZE       = DEF_SIZE,
    parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int FWD        = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            rd_req,
    input  logic [NREQ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NREQ-1:0]            rd_gnt,
    output logic [NREQ-1:0]            rd_valid,
    output logic [BIT_WIDTH-1:0]       rd_data,
    output logic [NREQ-1:0]            rd_err,
    input  logic [NREQ-1:0]            wr_req,
    input  logic [NREQ*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NREQ*BIT_WIDTH-1:0]  wr_data,
    output logic [NREQ-1:0]            wr_gnt,
    output logic [NREQ-1:0]            wr_err,
    output logic                       bram_re,
    output logic [ADDR_WIDTH-1:0]      bram_raddr,
    output logic                       bram_we,
    output logic [ADDR_WIDTH-1:0]      bram_waddr,
    output logic [BIT_WIDTH-1:0]       bram_wdi,
    input  logic [BIT_WIDTH-1:0]       bram_rdo
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [ADDR_WIDTH:0] SIZE_W = (ADDR_WIDTH + 1)'(SIZE);

    logic [ADDR_WIDTH-1:0] rd_addr_arr [NREQ];
    logic [ADDR_WIDTH-1:0] wr_addr_arr [NREQ];
    logic [BIT_WIDTH-1:0]  wr_data_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign rd_addr_arr[gi] = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wr_addr_arr[gi] = wr_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wr_data_arr[gi] = wr_data[gi*BIT_WIDTH +: BIT_WIDTH];
        end
    endgenerate

    // Requests are masked while reset is held so nothing is granted or written on that edge.
    logic [NREQ-1:0] rd_req_q, wr_req_q;
    logic [IW-1:0]   rd_idx, wr_idx;

    assign rd_req_q = rd_req & {NREQ{rst_n}};
    assign wr_req_q = wr_req & {NREQ{rst_n}};

    rr_arbiter #(.N(NREQ)) u_rd_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (rd_req_q),
        .gnt     (rd_gnt),
        .gnt_idx (rd_idx)
    );

    rr_arbiter #(.N(NREQ)) u_wr_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (wr_req_q),
        .gnt     (wr_gnt),
        .gnt_idx (wr_idx)
    );

    logic                  rd_any, wr_any, rd_oor, wr_oor;
    logic [ADDR_WIDTH-1:0] rd_sel_addr, wr_sel_addr;
    logic                  fwd_hit_next;

    assign rd_any      = |rd_gnt;
    assign wr_any      = |wr_gnt;
    assign rd_sel_addr = rd_addr_arr[rd_idx];
    assign wr_sel_addr = wr_addr_arr[wr_idx];
    assign rd_oor      = {1'b0, rd_sel_addr} >= SIZE_W;
    assign wr_oor      = {1'b0, wr_sel_addr} >= SIZE_W;

    assign bram_re    = rd_any & ~rd_oor;
    assign bram_raddr = rd_any ? rd_sel_addr : '0;
    assign bram_we    = wr_any & ~wr_oor;
    assign bram_waddr = wr_any ? wr_sel_addr : '0;
    assign bram_wdi   = wr_any ? wr_data_arr[wr_idx] : '0;

    // The BRAM returns pre-write contents on a same-address collision; capture the write to bypass it.
    assign fwd_hit_next = (FWD != 0) && bram_we && bram_re && (bram_waddr == bram_raddr);

    logic [NREQ-1:0]      rd_valid_reg, rd_err_reg, wr_err_reg;
    logic                 fwd_hit_reg;
    logic [BIT_WIDTH-1:0] fwd_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_reg <= '0;
            rd_err_reg   <= '0;
            wr_err_reg   <= '0;
            fwd_hit_reg  <= 1'b0;
            fwd_data_reg <= '0;
        end else begin
            rd_valid_reg <= rd_gnt;
            rd_err_reg   <= rd_oor ? rd_gnt : '0;
            wr_err_reg   <= wr_oor ? wr_gnt : '0;
            fwd_hit_reg  <= fwd_hit_next;
            if (fwd_hit_next) begin
                fwd_data_reg <= bram_wdi;
            end
        end
    end

    assign rd_valid = rd_valid_reg;
    assign rd_err   = rd_err_reg;
    assign wr_err   = wr_err_reg;
    assign rd_data  = (rd_any_valid() && !(|rd_err_reg)) ?
                      (fwd_hit_reg ? fwd_data_reg : bram_rdo) : '0;

    function automatic logic rd_any_valid();
        return |rd_valid_reg;
    endfunction

endmodule

// File: tb/tb_bram16_rr_arbiter.sv
// Scoreboard bench for bram16_rr_arbiter with a behavioural registered-read BRAM behind it.
module tb_bram16_rr_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 12;
    localparam int BW   = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NREQ-1:0]   rd_req, rd_gnt, rd_valid, rd_err;
    logic [NREQ*AW-1:0] rd_addr, wr_addr;
    logic [BW-1:0]     rd_data;
    logic [NREQ-1:0]   wr_req, wr_gnt, wr_err;
    logic [NREQ*BW-1:0] wr_data;
    logic              bram_re, bram_we;
    logic [AW-1:0]     bram_raddr, bram_waddr;
    logic [BW-1:0]     bram_wdi, bram_rdo;

    bram16_rr_arbiter #(
        .NREQ(NREQ), .ADDR_WIDTH(AW), .SIZE(16), .BIT_WIDTH(BW), .FWD(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_err(rd_err),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt), .wr_err(wr_err),
        .bram_re(bram_re), .bram_raddr(bram_raddr), .bram_we(bram_we),
        .bram_waddr(bram_waddr), .bram_wdi(bram_wdi), .bram_rdo(bram_rdo)
    );

    always #5 clk = ~clk;

    // Read-first BRAM model: a same-edge read returns the old word.
    logic [BW-1:0] mem [16];
    always @(posedge clk) begin
        if (bram_we) mem[bram_waddr[3:0]] <= bram_wdi;
        if (bram_re) bram_rdo <= mem[bram_raddr[3:0]];
    end

    typedef struct packed {
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] e;
        logic [BW-1:0]   d;
    } rd_exp_t;

    rd_exp_t         rd_q [$];
    logic [NREQ-1:0] wr_q [$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: consumes expected responses whenever the DUT presents one.
    always @(negedge clk) begin
        if (rd_valid !== '0) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", 64'(rd_valid), 64'(0));
            end else begin
                rd_exp_t x;
                x = rd_q.pop_front();
                check("rd_valid", 64'(rd_valid), 64'(x.v));
                check("rd_err", 64'(rd_err), 64'(x.e));
                check("rd_data", 64'(rd_data), 64'(x.d));
                $display("rd resp valid=%b err=%b data=%h", rd_valid, rd_err, rd_data);
            end
        end
        if (wr_err !== '0) begin
            if (wr_q.size() == 0) begin
                check("wr_err_unexpected", 64'(wr_err), 64'(0));
            end else begin
                logic [NREQ-1:0] w;
                w = wr_q.pop_front();
                check("wr_err", 64'(wr_err), 64'(w));
                $display("wr err resp wr_err=%b", wr_err);
            end
        end
    end

    // One request cycle: drive, check combinational grants at negedge, queue expected responses.
    task automatic step(input logic [1:0] rr, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                        input logic [1:0] wr, input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                        input logic [BW-1:0] wd0, input logic [BW-1:0] wd1,
                        input logic [1:0] erg, input logic erer, input logic [BW-1:0] erd,
                        input logic [1:0] ewg, input logic ewer);
        rd_req  = rr;
        rd_addr = {ra1, ra0};
        wr_req  = wr;
        wr_addr = {wa1, wa0};
        wr_data = {wd1, wd0};
        @(negedge clk);
        check("rd_gnt", 64'(rd_gnt), 64'(erg));
        check("wr_gnt", 64'(wr_gnt), 64'(ewg));
        check("bram_re", 64'(bram_re), 64'((erg != 0) && !erer));
        check("bram_we", 64'(bram_we), 64'((ewg != 0) && !ewer));
        $display("req rd=%b gnt=%b raddr=%0d | wr=%b gnt=%b waddr=%0d wdi=%h", rr, rd_gnt,
                 bram_raddr, wr, wr_gnt, bram_waddr, bram_wdi);
        if (erg != 0) rd_q.push_back('{v: erg, e: (erer ? erg : 2'b00), d: (erer ? '0 : erd)});
        if (ewer) wr_q.push_back(ewg);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0, 0, 2'b00, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_req = '0; rd_addr = '0; wr_req = '0; wr_addr = '0; wr_data = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", 64'({rd_valid, rd_err, wr_err, rd_gnt, wr_gnt}), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 10; i++) begin
            idle();
            check("idle_regs", 64'({rd_valid, rd_err, wr_err}), 64'(0));
        end

        // preload
        step(2'b00, 0, 0, 2'b01, 3, 0, 32'h1111_1111, 0, 2'b00, 1'b0, 0, 2'b01, 1'b0);
        step(2'b00, 0, 0, 2'b01, 5, 0, 32'h2222_2222, 0, 2'b00, 1'b0, 0, 2'b01, 1'b0);
        step(2'b00, 0, 0, 2'b10, 0, 7, 0, 32'hA5A5_A5A5, 2'b00, 1'b0, 0, 2'b10, 1'b0);

        // 2: both readers held, grants alternate
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                step(2'b11, 3, 5, 2'b00, 0, 0, 0, 0, 2'b01, 1'b0, 32'h1111_1111, 2'b00, 1'b0);
            else
                step(2'b11, 3, 5, 2'b00, 0, 0, 0, 0, 2'b10, 1'b0, 32'h2222_2222, 2'b00, 1'b0);
        end

        // 3: write then read next cycle
        step(2'b00, 0, 0, 2'b01, 4, 0, 32'hDEAD_BEEF, 0, 2'b00, 1'b0, 0, 2'b01, 1'b0);
        step(2'b10, 0, 4, 2'b00, 0, 0, 0, 0, 2'b10, 1'b0, 32'hDEAD_BEEF, 2'b00, 1'b0);

        // 4: same-cycle collision forwarded, then memory holds the new word
        step(2'b01, 7, 0, 2'b10, 0, 7, 0, 32'h1234_5678, 2'b01, 1'b0, 32'h1234_5678, 2'b10, 1'b0);
        step(2'b01, 7, 0, 2'b00, 0, 0, 0, 0, 2'b01, 1'b0, 32'h1234_5678, 2'b00, 1'b0);

        // 5: out-of-range read and write; aliased location 4 must be untouched
        step(2'b01, 16, 0, 2'b10, 0, 20, 0, 32'hBAD0_BAD0, 2'b01, 1'b1, 0, 2'b10, 1'b1);
        step(2'b10, 0, 4, 2'b00, 0, 0, 0, 0, 2'b10, 1'b0, 32'hDEAD_BEEF, 2'b00, 1'b0);

        // concurrent read and write traffic from both requesters
        step(2'b11, 3, 7, 2'b11, 8, 9, 32'hCAFE_0008, 32'hCAFE_0009, 2'b01, 1'b0, 32'h1111_1111, 2'b01, 1'b0);
        step(2'b10, 0, 7, 2'b10, 0, 9, 0, 32'hCAFE_0009, 2'b10, 1'b0, 32'h1234_5678, 2'b10, 1'b0);
        step(2'b11, 8, 9, 2'b00, 0, 0, 0, 0, 2'b01, 1'b0, 32'hCAFE_0008, 2'b00, 1'b0);
        step(2'b10, 0, 9, 2'b00, 0, 0, 0, 0, 2'b10, 1'b0, 32'hCAFE_0009, 2'b00, 1'b0);

        // move both pointers to requester 0 so the reset test can see them return
        step(2'b01, 3, 0, 2'b01, 10, 0, 32'h0000_000A, 0, 2'b01, 1'b0, 32'h1111_1111, 2'b01, 1'b0);

        // 6: reset lands before the read grant edge
        rd_req  = 2'b01;
        rd_addr = {12'd0, 12'd3};
        wr_req  = 2'b00;
        @(negedge clk);
        check("t6_gnt", 64'(rd_gnt), 64'(2'b01));
        #2 rst_n = 1'b0;
        #1 check("t6_gnt_in_rst", 64'({rd_gnt, wr_gnt}), 64'(0));
        rd_req = 2'b00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t6_rd_valid", 64'(rd_valid), 64'(0));
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(2'b11, 3, 5, 2'b11, 11, 12, 32'h0B0B_0B0B, 32'h0C0C_0C0C, 2'b01, 1'b0, 32'h1111_1111, 2'b01, 1'b0);

        repeat (3) idle();
        check("rd_q_drained", 64'(rd_q.size()), 64'(0));
        check("wr_q_drained", 64'(wr_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
